// File: rtl/free_list.sv
// free_list: 3-wide physical-register free list (circular buffer with speculative head, retire head, tail).
// Define FREELIST_CHECK_EN to add the sticky fl_error output for reclaim overflow / PR0 reclaim.
module free_list #(
  parameter  int PR_NUM = 64,
  parameter  int AR_NUM = 32,
  parameter  int WIDTH  = 3,
  localparam int PR     = $clog2(PR_NUM),
  localparam int DEPTH  = PR_NUM - AR_NUM,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = PW + 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          dispatch_valid,
  input  logic                      BPRecoverEN,
  input  logic [WIDTH-1:0]          retire_valid,
  input  logic [WIDTH-1:0][PR-1:0]  retire_told,
  output logic [WIDTH-1:0][PR-1:0]  free_pr,
  output logic [CW-1:0]             free_count,
  output logic                      stall
`ifdef FREELIST_CHECK_EN
  ,
  output logic                      fl_error
`endif
);

  localparam logic [CW:0]   DEPTH_X = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PR-1:0] entry_q [DEPTH];
  logic [PR-1:0] entry_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] rhead_q, rhead_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] free_count_q, free_count_d;

  logic [CW-1:0] n_req, n_ret, alloc;
  logic [CW-1:0] rd_ofs, wr_ofs;
  logic [CW:0]   count_sum;

  // Pointer add modulo DEPTH; increments never exceed DEPTH so one wrap suffices.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [CW-1:0] n);
    logic [CW:0] s;
    s = {2'b00, p} + {1'b0, n};
    if (s >= DEPTH_X) s = s - DEPTH_X;
    return s[PW-1:0];
  endfunction

  always_comb begin
    n_req = '0;
    n_ret = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n_req = n_req + CW'(dispatch_valid[i]);
      n_ret = n_ret + CW'(retire_valid[i]);
    end
  end

  // Each requesting slot takes the next entry after those claimed by lower slots.
  always_comb begin
    rd_ofs  = '0;
    free_pr = '0;
    for (int i = 0; i < WIDTH; i++) begin
      free_pr[i] = entry_q[ptr_add(head_q, rd_ofs)];
      rd_ofs     = rd_ofs + CW'(dispatch_valid[i]);
    end
  end

  assign stall = (n_req > free_count_q) && !BPRecoverEN;
  assign alloc = (stall || BPRecoverEN) ? '0 : n_req;

  always_comb begin
    wr_ofs = '0;
    for (int i = 0; i < DEPTH; i++) entry_d[i] = entry_q[i];
    for (int i = 0; i < WIDTH; i++) begin
      if (retire_valid[i]) begin
        entry_d[ptr_add(tail_q, wr_ofs)] = retire_told[i];
        wr_ofs = wr_ofs + CW'(1);
      end
    end
  end

  always_comb begin
    count_sum    = {1'b0, free_count_q} + {1'b0, n_ret} - {1'b0, alloc};
    rhead_d      = ptr_add(rhead_q, n_ret);
    tail_d       = ptr_add(tail_q, n_ret);
    head_d       = BPRecoverEN ? rhead_d : ptr_add(head_q, alloc);
    free_count_d = BPRecoverEN ? DEPTH_C : count_sum[CW-1:0];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= PR'(AR_NUM + i);
      head_q       <= '0;
      rhead_q      <= '0;
      tail_q       <= '0;
      free_count_q <= DEPTH_C;
    end else begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
      head_q       <= head_d;
      rhead_q      <= rhead_d;
      tail_q       <= tail_d;
      free_count_q <= free_count_d;
    end
  end

  assign free_count = free_count_q;

`ifdef FREELIST_CHECK_EN
  logic fl_error_q, fl_error_d;
  logic overflow, told_zero;

  always_comb begin
    told_zero = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (retire_valid[i] && (retire_told[i] == '0)) told_zero = 1'b1;
    end
    overflow   = count_sum > DEPTH_X;
    fl_error_d = fl_error_q | overflow | told_zero;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      fl_error_q <= 1'b0;
    end else begin
      fl_error_q <= fl_error_d;
      if (overflow)  $error("free_list: reclaim overflow");
      if (told_zero) $error("free_list: reclaimed PR 0");
    end
  end

  assign fl_error = fl_error_q;
`endif

endmodule
